adder_share_sched: RTL
======================

Name: adder_share_sched

Overview:
- Schedules one shared registered 6-bit adder across NREQ requesters.
- Arbitration is round-robin, with one issue opportunity per DIV-cycle clock-enable tick. This tick replaces a divided/derived clock; the whole block runs on one clock.
- Requesters use valid/ready handshakes. Results return on a single tagged output with valid/ready backpressure.
- Sits between the tile input pins (operand sources) and the uo_out result path.

Parameters:
- NREQ, 4, number of requesters; must be ≥2.
- OPW, 6, operand width in bits.
- DIV, 2, issue-tick period in clk cycles; must be ≥1. DIV=1 gives a tick every cycle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*OPW  packed operand A; requester i uses [i*OPW +: OPW]
- req_b  in  NREQ*OPW  packed operand B; same packing as req_a
- req_ready  out  NREQ  one-hot grant/accept pulse
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  OPW+1  sum, carry in the MSB
- res_id  out  clog2(NREQ)  index of the requester that owns res_sum
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1) clears everything:
  - tick counter cnt=0, state=IDLE, rr pointer ptr=0
  - operand and result registers = 0
  - res_valid=0, req_ready=0, busy=0
  - Reset asserted mid-operation abandons that operation with no result. Outputs are clear immediately while rst=1; the first possible grant is at the first tick after release.
- Tick generation:
  - cnt counts 0..DIV-1 and wraps.
  - tick=1 in cycles where cnt==DIV-1.
  - cnt runs freely in every state.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - If tick=1 and |req_valid, the winner w is the first set req_valid bit searching ptr, ptr+1, … with modulo-NREQ wrap.
  - req_ready[w]=1 combinationally in that cycle only, which completes the handshake.
  - Capture: a_r<=req_a[w], b_r<=req_b[w], id_r<=w.
  - ptr<=(w+1) mod NREQ. From ptr=NREQ-1 the pointer wraps to 0.
  - Next state: CALC.
  - With no tick, or no valid requests, stay in IDLE with req_ready=0.
- CALC: res_sum<=a_r+b_r, zero-extended to OPW+1 bits with no truncation; res_id<=id_r; next state HOLD.
- HOLD:
  - res_valid=1.
  - If res_ready=1, the transfer completes and the next state is IDLE.
  - Otherwise stay in HOLD; res_sum and res_id stay stable and req_ready stays 0.
- Latency: grant at cycle T gives res_valid=1 at T+2.
- Grant window: the earliest next grant is the first tick in a cycle at or after the return to IDLE. Ticks occurring in CALC or HOLD are lost, not queued.
- Off-tick grants: req_ready is never asserted outside IDLE with tick=1.
- Requesters may drop req_valid at any time before their grant without side effects.
- res_sum/res_id hold their last value after the transfer; res_valid returns to 0.
- A request arriving in the same cycle as its tick is eligible.
- If ptr's own requester is invalid, the search continues cyclically.

Decomposition:
- Shared package adder_sched_pkg:
  - state enum {IDLE, CALC, HOLD}
  - localparam IDW = clog2(NREQ), with IDW ≥ 1
  - function rr_pick(valid, ptr) returning {found, index}
- One sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: valid, ptr, en.
  - Output: one-hot gnt, gnt_idx.
  - Purely combinational.
  - The pointer register stays in adder_share_sched.

Test Plan:
- Single request, DIV=2: req_valid=0001, a=5, b=9 at cnt=0.
  - Required: req_ready=0001 in the cnt=1 cycle; res_valid two cycles later with res_sum=14, res_id=0; res_ready=1 returns the FSM to IDLE.
- Round-robin: req_valid=1111 held continuously, res_ready=1, ptr=0 after reset.
  - Required: grant order 0,1,2,3,0.
  - Then req_valid=1010 with ptr=1: grant order 1,3,1.
- Backpressure: hold res_ready=0 for 5 cycles during HOLD.
  - Required: res_valid stays 1; res_sum/res_id stay stable; req_ready stays 0000 despite ticks and valid requests.
  - Release res_ready: next grant only at the first subsequent tick.
- Overflow: a=63, b=63.
  - Required: res_sum=126 (7'b1111110).
  - a=63, b=1 gives res_sum=64, carry set.
- Reset mid-operation: assert rst during CALC.
  - Required: res_valid=0, busy=0, ptr=0, cnt=0 immediately.
  - After release with req_valid=0100: first grant goes to 2 at cnt==DIV-1.
- DIV=1 and DIV=3 builds:
  - DIV=1: back-to-back grants every 3 cycles with res_ready=1.
  - DIV=3: ticks every 3rd cycle; a grant only on cycles with cnt==2.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types and round-robin helper for adder_share_sched
//
// Purpose : FSM state type, requester-index width helper and the cyclic
//           first-set search shared by the scheduler and its arbiter.
// Contents: state_t, idw_of(), IDW, pick_t, rr_pick()
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // rr_pick works on a fixed-width vector so one function serves every
  // NREQ up to MAX_NREQ; callers zero-extend their request vector.
  localparam int MAX_NREQ     = 16;
  localparam int MAX_IDW      = 4;
  localparam int NREQ_DEFAULT = 4;

  // Index width for n requesters, never below one bit.
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW = idw_of(NREQ_DEFAULT);

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First set bit of valid[0 +: n], searching ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                    input int n, input int ptr);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!r.found && valid[j[MAX_IDW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[MAX_IDW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : picks one requester starting from ptr; grants only when en=1.
// Ports   : valid   in  NREQ  request vector
//           ptr     in  IDW   highest-priority requester index
//           en      in  1     issue opportunity this cycle
//           gnt     out NREQ  one-hot grant (zero when en=0 or no valid)
//           gnt_idx out IDW   index of the selected requester
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int AIDW = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [AIDW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [AIDW-1:0] gnt_idx
);

  logic [MAX_NREQ-1:0] w_valid_ext;
  pick_t               w_pick;
  logic                w_unused;

  assign w_valid_ext = MAX_NREQ'(valid);
  assign w_pick      = rr_pick(w_valid_ext, NREQ, int'(ptr));
  // Upper index bits are always zero for NREQ below MAX_NREQ.
  assign w_unused    = ^w_pick.idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = w_pick.idx[AIDW-1:0];
    if (en && w_pick.found) gnt[w_pick.idx[AIDW-1:0]] = 1'b1;
  end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin scheduler for one shared registered adder
//
// Purpose : grants one requester per DIV-cycle tick, adds its operands in
//           CALC and presents the tagged sum in HOLD until accepted.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_a/req_b in, req_ready out   requester side
//           res_valid/res_sum/res_id out, res_ready in  result side
//           busy out   high whenever the FSM is not IDLE
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OPW  = 6,
  parameter int DIV  = 2,
  localparam int SIDW = idw_of(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OPW:0]        res_sum,
  output logic [SIDW-1:0]     res_id,
  output logic                busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SIDW-1:0] r_ptr;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [SIDW-1:0] r_id;
  logic [OPW:0]    r_sum;
  logic [SIDW-1:0] r_res_id;

  logic            w_tick;
  logic            w_issue_en;
  logic [NREQ-1:0] w_gnt;
  logic [SIDW-1:0] w_gnt_idx;
  logic [OPW-1:0]  w_a;
  logic [OPW-1:0]  w_b;

  assign w_tick = (r_cnt == CW'(DIV - 1));
  // rst gating keeps req_ready low during reset even when DIV=1 makes the
  // held-at-zero counter look like a tick.
  assign w_issue_en = (r_state == IDLE) && w_tick && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid   (req_valid),
    .ptr     (r_ptr),
    .en      (w_issue_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_a = req_a[w_gnt_idx*OPW +: OPW];
  assign w_b = req_b[w_gnt_idx*OPW +: OPW];

  assign req_ready = w_gnt;
  assign res_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign res_sum   = r_sum;
  assign res_id    = r_res_id;

  // Free-running tick counter, independent of the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= '0;
      r_sum    <= '0;
      r_res_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_gnt_idx;
            r_ptr   <= (w_gnt_idx == SIDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_sum    <= {1'b0, r_a} + {1'b0, r_b};
          r_res_id <= r_id;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
